// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter granting at most one write per
// cycle from NUM_REQ requesters into a bank of NUM_REGS enable-gated registers.
// Optional requester lock: define REGFILE_WR_LOCK_EN to add the wr_lock port.
module regfile_write_arbiter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned ADDR_W     = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             wr_req,
    input  logic [NUM_REQ*ADDR_W-1:0]      wr_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  wr_data,
`ifdef REGFILE_WR_LOCK_EN
    input  logic [NUM_REQ-1:0]             wr_lock,
`endif
    output logic [NUM_REQ-1:0]             wr_ack,
    output logic [NUM_REGS-1:0]            reg_en,
    output logic [DATA_WIDTH-1:0]          reg_data,
    output logic                           busy,
    output logic                           addr_err
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned AW1   = ADDR_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [NUM_REQ-1:0]      r_ack;
    logic [NUM_REQ-1:0]      w_ack_nxt;
    logic [NUM_REQ-1:0]      w_eligible;
    logic [PTR_W-1:0]        r_rr_ptr;
    logic [PTR_W-1:0]        w_rr_ptr_nxt;
    logic [PTR_W-1:0]        w_win;
    logic                    w_grant;
    logic                    w_locked;
    logic [NUM_REGS-1:0]     r_reg_en;
    logic [NUM_REGS-1:0]     w_reg_en_nxt;
    logic [DATA_WIDTH-1:0]   r_reg_data;
    logic [DATA_WIDTH-1:0]   w_reg_data_nxt;
    logic                    r_addr_err;
    logic                    w_addr_err_nxt;
    logic [ADDR_W-1:0]       w_win_addr;

`ifdef REGFILE_WR_LOCK_EN
    logic [PTR_W-1:0]        r_last;
    logic                    r_last_vld;
`endif

    // Eligible requesters: the one acked this cycle is masked; a held lock masks all others.
    always_comb begin
        w_locked   = 1'b0;
        w_eligible = wr_req & ~r_ack;
`ifdef REGFILE_WR_LOCK_EN
        w_locked = r_last_vld & wr_lock[r_last] & wr_req[r_last];
        if (w_locked) begin
            w_eligible = w_eligible & (NUM_REQ'(1) << r_last);
        end
`endif
    end

    // Round-robin scan starting at r_rr_ptr, wrapping at NUM_REQ; first set bit wins.
    always_comb begin
        int unsigned idx;
        w_grant = 1'b0;
        w_win   = '0;
        idx     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_grant && w_eligible[PTR_W'(idx)]) begin
                w_grant = 1'b1;
                w_win   = PTR_W'(idx);
            end
        end
    end

    // FSM next state and next values of all registered outputs.
    always_comb begin
        w_state_nxt    = r_state;
        w_ack_nxt      = '0;
        w_reg_en_nxt   = '0;
        w_reg_data_nxt = r_reg_data;
        w_addr_err_nxt = r_addr_err;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_win_addr     = wr_addr[32'(w_win)*ADDR_W +: ADDR_W];

        case (r_state)
            IDLE:    if (|w_eligible)  w_state_nxt = WRITE;
            WRITE:   if (!(|w_eligible)) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        if (w_grant) begin
            w_ack_nxt      = NUM_REQ'(1) << w_win;
            w_reg_data_nxt = wr_data[32'(w_win)*DATA_WIDTH +: DATA_WIDTH];
            if (AW1'(w_win_addr) < AW1'(NUM_REGS)) begin
                w_reg_en_nxt = NUM_REGS'(1) << w_win_addr;
            end else begin
                // Out-of-range write still acks so the requester is never hung.
                w_addr_err_nxt = 1'b1;
            end
            if (!w_locked) begin
                w_rr_ptr_nxt = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : (w_win + PTR_W'(1));
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ack      <= '0;
            r_reg_en   <= '0;
            r_reg_data <= '0;
            r_addr_err <= 1'b0;
            r_rr_ptr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ack      <= w_ack_nxt;
            r_reg_en   <= w_reg_en_nxt;
            r_reg_data <= w_reg_data_nxt;
            r_addr_err <= w_addr_err_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
        end
    end

`ifdef REGFILE_WR_LOCK_EN
    // Track the most recent winner as the candidate lock owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last     <= '0;
            r_last_vld <= 1'b0;
        end else if (w_grant) begin
            r_last     <= w_win;
            r_last_vld <= 1'b1;
        end
    end
`endif

    assign wr_ack   = r_ack;
    assign reg_en   = r_reg_en;
    assign reg_data = r_reg_data;
    assign addr_err = r_addr_err;
    assign busy     = (r_state == WRITE);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter (NUM_REGS=6 so addresses 6 and 7 are out of range).
module tb_regfile_write_arbiter;

    localparam int unsigned DW = 16;
    localparam int unsigned NR = 4;
    localparam int unsigned NG = 6;
    localparam int unsigned AW = 3;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     wr_req;
    logic [NR*AW-1:0]  wr_addr;
    logic [NR*DW-1:0]  wr_data;
`ifdef REGFILE_WR_LOCK_EN
    logic [NR-1:0]     wr_lock;
`endif
    logic [NR-1:0]     wr_ack;
    logic [NG-1:0]     reg_en;
    logic [DW-1:0]     reg_data;
    logic              busy;
    logic              addr_err;

    regfile_write_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .NUM_REGS   (NG),
        .ADDR_W     (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
`ifdef REGFILE_WR_LOCK_EN
        .wr_lock  (wr_lock),
`endif
        .wr_ack   (wr_ack),
        .reg_en   (reg_en),
        .reg_data (reg_data),
        .busy     (busy),
        .addr_err (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NR-1:0] ack;
        logic [NG-1:0] en;
        logic [DW-1:0] data;
        logic          busy;
        logic          err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [NR-1:0] m_ack  = '0;
    logic [DW-1:0] m_data = '0;
    logic          m_err  = 1'b0;
    int            m_ptr  = 0;
    int            m_last = 0;
    bit            m_last_vld = 1'b0;

    // Model one clock edge from the inputs as sampled at that edge; push expectation.
    task automatic model_edge();
        exp_t          e;
        logic [NR-1:0] elig;
        logic [AW-1:0] a;
        int            win;
        bit            lk;
        e   = '0;
        lk  = 1'b0;
        win = -1;
        if (rst) begin
            m_ack = '0; m_data = '0; m_err = 1'b0; m_ptr = 0; m_last_vld = 1'b0;
        end else begin
            elig = wr_req & ~m_ack;
`ifdef REGFILE_WR_LOCK_EN
            lk = m_last_vld && wr_lock[m_last] && wr_req[m_last];
            if (lk) elig = elig & (NR'(1) << m_last);
`endif
            for (int k = 0; k < int'(NR); k++) begin
                int j;
                j = (m_ptr + k) % int'(NR);
                if (win < 0 && elig[j]) win = j;
            end
            m_ack = '0;
            if (win >= 0) begin
                m_ack  = NR'(1) << win;
                a      = wr_addr[win*AW +: AW];
                m_data = wr_data[win*DW +: DW];
                if (int'(a) < int'(NG)) e.en = NG'(1) << a;
                else m_err = 1'b1;
                if (!lk) m_ptr = (win + 1) % int'(NR);
                m_last = win;
                m_last_vld = 1'b1;
            end
        end
        e.ack  = m_ack;
        e.data = m_data;
        e.err  = m_err;
        e.busy = (m_ack != '0);
        sb_q.push_back(e);
    endtask

    // Advance one clock: model the edge, then compare the DUT against the queued expectation.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        e = sb_q.pop_front();
        checks++; if (wr_ack !== e.ack) begin errors++; $display("FAIL sb_ack t=%0t got %b exp %b", $time, wr_ack, e.ack); end
        checks++; if (reg_en !== e.en) begin errors++; $display("FAIL sb_en t=%0t got %b exp %b", $time, reg_en, e.en); end
        checks++; if (reg_data !== e.data) begin errors++; $display("FAIL sb_data t=%0t got %h exp %h", $time, reg_data, e.data); end
        checks++; if (busy !== e.busy) begin errors++; $display("FAIL sb_busy t=%0t got %b exp %b", $time, busy, e.busy); end
        checks++; if (addr_err !== e.err) begin errors++; $display("FAIL sb_err t=%0t got %b exp %b", $time, addr_err, e.err); end
        checks++;
        if (!$onehot0(wr_ack) || !$onehot0(reg_en) || (reg_en != '0 && wr_ack == '0)) begin
            errors++; $display("FAIL invariant t=%0t ack %b en %b", $time, wr_ack, reg_en);
        end
    endtask

    task automatic set_req(input int i, input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_req[i] = r;
        wr_addr[i*AW +: AW] = a;
        wr_data[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(); cycle();
        checks++; if (wr_ack !== '0 || reg_en !== '0 || busy !== 1'b0) begin errors++; $display("FAIL reset_outputs got ack %b en %b busy %b exp 0", wr_ack, reg_en, busy); end
        checks++; if (reg_data !== '0 || addr_err !== 1'b0) begin errors++; $display("FAIL reset_data got %h err %b exp 0", reg_data, addr_err); end
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        set_req(0, 1'b1, 3'd5, 16'hBEEF);
        cycle();
        checks++; if (wr_ack !== 4'b0001) begin errors++; $display("FAIL single_ack got %b exp 0001", wr_ack); end
        checks++; if (reg_en !== 6'b100000) begin errors++; $display("FAIL single_en got %b exp 100000", reg_en); end
        checks++; if (reg_data !== 16'hBEEF || busy !== 1'b1) begin errors++; $display("FAIL single_data got %h busy %b exp beef 1", reg_data, busy); end
        set_req(0, 1'b0, 3'd5, 16'hBEEF);
        cycle();
        checks++; if (wr_ack !== '0 || reg_en !== '0) begin errors++; $display("FAIL single_after got ack %b en %b exp 0", wr_ack, reg_en); end
        checks++; if (reg_data !== 16'hBEEF) begin errors++; $display("FAIL single_hold got %h exp beef", reg_data); end
    endtask

    task automatic test_fairness();
        int exp_w;
        rst = 1'b1; wr_req = '0;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < int'(NR); i++) set_req(i, 1'b1, AW'(i), DW'(16'hA000 + i));
        exp_w = 0;
        for (int n = 0; n < 12; n++) begin
            cycle();
            checks++; if (wr_ack !== (NR'(1) << exp_w)) begin errors++; $display("FAIL fair_order n=%0d got %b exp %b", n, wr_ack, NR'(1) << exp_w); end
            checks++; if (reg_en === '0) begin errors++; $display("FAIL fair_idle n=%0d got en %b exp nonzero", n, reg_en); end
            exp_w = (exp_w + 1) % int'(NR);
        end
        wr_req = '0;
        cycle();
    endtask

    task automatic test_ack_mask();
        cycle();
        set_req(2, 1'b1, 3'd3, 16'h1234);
        for (int n = 0; n < 6; n++) begin
            cycle();
            checks++; if (wr_ack[2] !== ((n % 2) == 0)) begin errors++; $display("FAIL mask_pulse n=%0d got %b exp %b", n, wr_ack[2], (n % 2) == 0); end
        end
        wr_req = '0;
        cycle();
    endtask

    task automatic test_addr_err();
        set_req(1, 1'b1, 3'd7, 16'h0BAD);
        cycle();
        checks++; if (wr_ack !== 4'b0010 || reg_en !== '0) begin errors++; $display("FAIL err_grant got ack %b en %b exp 0010 0", wr_ack, reg_en); end
        checks++; if (addr_err !== 1'b1 || reg_data !== 16'h0BAD) begin errors++; $display("FAIL err_flag got %b data %h exp 1 0bad", addr_err, reg_data); end
        wr_req = '0;
        cycle();
        set_req(0, 1'b1, 3'd5, 16'h5555);
        cycle();
        checks++; if (reg_en !== 6'b100000 || addr_err !== 1'b1) begin errors++; $display("FAIL err_sticky got en %b err %b exp 100000 1", reg_en, addr_err); end
        wr_req = '0;
        set_req(2, 1'b1, 3'd6, 16'h6666);
        cycle();
        checks++; if (wr_ack !== 4'b0100 || reg_en !== '0) begin errors++; $display("FAIL err_boundary got ack %b en %b exp 0100 0", wr_ack, reg_en); end
        wr_req = '0;
        rst = 1'b1;
        cycle();
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", addr_err); end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        set_req(1, 1'b1, 3'd7, 16'h0BAD);
        cycle();
        wr_req = '0;
        set_req(3, 1'b1, 3'd2, 16'h3333);
        rst = 1'b1;
        cycle();
        checks++; if (wr_ack !== '0 || reg_en !== '0 || addr_err !== 1'b0) begin errors++; $display("FAIL midrst got ack %b en %b err %b exp 0", wr_ack, reg_en, addr_err); end
        rst = 1'b0;
        cycle();
        checks++; if (wr_ack !== 4'b1000 || reg_en !== 6'b000100 || reg_data !== 16'h3333) begin errors++; $display("FAIL midrst_grant got ack %b en %b data %h exp 1000 000100 3333", wr_ack, reg_en, reg_data); end
        wr_req = '0;
        cycle();
    endtask

`ifdef REGFILE_WR_LOCK_EN
    task automatic test_lock();
        bit got;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        wr_lock = 4'b0001;
        set_req(0, 1'b1, 3'd1, 16'hAAAA);
        set_req(1, 1'b1, 3'd2, 16'hBBBB);
        for (int n = 0; n < 6; n++) begin
            cycle();
            checks++; if (wr_ack[1] !== 1'b0 || wr_ack[0] !== ((n % 2) == 0)) begin errors++; $display("FAIL lock_hold n=%0d got ack %b", n, wr_ack); end
        end
        wr_lock = '0;
        got = 1'b0;
        for (int n = 0; n < 2 && !got; n++) begin
            cycle();
            if (wr_ack[1] === 1'b1) got = 1'b1;
        end
        checks++; if (!got) begin errors++; $display("FAIL lock_release got no ack for req1 exp ack within 2 cycles"); end
        wr_req = '0;
        cycle();
    endtask
`endif

    initial begin
        rst     = 1'b1;
        wr_req  = '0;
        wr_addr = '0;
        wr_data = '0;
`ifdef REGFILE_WR_LOCK_EN
        wr_lock = '0;
`endif
        test_reset();
        test_single_write();
        test_fairness();
        test_ack_mask();
        test_addr_err();
        test_reset_mid();
`ifdef REGFILE_WR_LOCK_EN
        test_lock();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Round-robin arbiter that shares a bank of NUM_REGS 16-bit enable-gated registers between NUM_REQ write requesters.
- Each requester presents a request, an address and data. The block grants at most one write per cycle.
- It drives a one-hot register enable vector and a shared data bus that feed the register bank's en/in pins, and returns a one-cycle ack to the winner.

Parameters:
- DATA_WIDTH, 16, width of each register and of each requester's data.
- NUM_REQ, 4, number of requesters (2..8).
- NUM_REGS, 8, number of registers in the bank (2..16).
- ADDR_W, 3, register address width; must satisfy 2**ADDR_W >= NUM_REGS.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- wr_req  input  NUM_REQ  request per requester; held high until its ack.
- wr_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- wr_data  input  NUM_REQ*DATA_WIDTH  packed data; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- wr_ack  output  NUM_REQ  one-hot, one-cycle grant acknowledge.
- reg_en  output  NUM_REGS  one-hot write enable to the register bank.
- reg_data  output  DATA_WIDTH  shared write data to the register bank.
- busy  output  1  high in any cycle where reg_en or an error ack is issued.
- addr_err  output  1  sticky; set on a write to an address >= NUM_REGS.

Behaviour:
- Reset: single clock, clk; reset is synchronous and active-high on rst. While rst is high at a posedge, the following all go to 0:
  - wr_ack, reg_en, reg_data, busy and addr_err;
  - the round-robin pointer rr_ptr;
  - state, which returns to IDLE.
- Reset mid-operation: any pending grant is discarded with no ack. Requesters keep their requests asserted.
- All outputs are registered. A request sampled at edge k produces wr_ack/reg_en/reg_data valid from edge k to edge k+1. The register bank captures at edge k+1.
- Eligibility: eligible = wr_req & ~wr_ack. The requester acked in the current cycle is masked. This prevents a double write while it drops or updates its request, so each requester gets at most one write per 2 cycles.
- Arbitration:
  - Scan eligible starting at index rr_ptr, ascending with wrap at NUM_REQ.
  - The first set bit wins.
  - On a grant to winner w, rr_ptr <= (w+1) mod NUM_REQ. With no grant, rr_ptr holds.
- State machine, 2 states:
  - IDLE: no write issued this cycle. If eligible != 0, go to WRITE; else stay in IDLE.
  - WRITE: issuing a write this cycle. If eligible != 0, stay in WRITE (back-to-back from different requesters); else go to IDLE.
  - busy = (state == WRITE).
- On a grant to w with address a:
  - wr_ack[w] <= 1 and reg_data <= data of w.
  - If a < NUM_REGS: reg_en <= 1<<a.
  - Else: reg_en <= 0 and addr_err <= 1. The ack is still issued, so the requester is not hung.
- With no grant: wr_ack <= 0, reg_en <= 0, and reg_data holds its last value.
- Invariants: wr_ack is always zero or one-hot. reg_en is always zero or one-hot. reg_en is nonzero only when wr_ack is nonzero.
- addr_err clears only on rst.
- A request dropped before it is acked is simply not granted. No state is kept per request.

Optional Feature:
- Macro: REGFILE_WR_LOCK_EN.
- When defined:
  - Adds port wr_lock, input, NUM_REQ.
  - If the last winner L has wr_lock[L]=1 and wr_req[L]=1, L keeps ownership and every other requester is masked.
  - L is still subject to the ack mask, so it gets one write every 2 cycles and the bank idles on the in-between cycles.
  - rr_ptr is frozen while locked.
  - Ownership is released when wr_lock[L] or wr_req[L] falls. Normal round-robin then resumes from rr_ptr.
- When undefined: no wr_lock port, and arbitration is pure round-robin.

Test Plan:
- Reset then single write: req0 with addr=5, data=16'hBEEF -> next cycle wr_ack=4'b0001, reg_en=8'b0010_0000, reg_data=16'hBEEF, busy=1. The following cycle wr_ack=0, reg_en=0.
- All-request fairness: req=4'b1111 held continuously with distinct addresses -> grant order 0,1,2,3,0,… Masking skips each requester for one cycle but never starves it, and reg_en is never zero while eligible requesters remain.
- Ack masking: only req2 held high for 6 cycles -> wr_ack[2] pulses every other cycle (1,0,1,0,1,0). Never two consecutive acks.
- Address error with NUM_REGS=6, ADDR_W=3: req1 with addr=7 -> wr_ack=4'b0010, reg_en=0, addr_err=1. addr_err stays 1 through later valid writes and clears only on rst.
- Reset mid-operation: assert rst in the same cycle req3 is sampled -> wr_ack, reg_en and addr_err are 0 and rr_ptr=0. After rst deasserts, req3 is granted first.
- Lock (with REGFILE_WR_LOCK_EN defined): req0 wins with wr_lock[0]=1 while req1 is also requesting -> req1 gets no ack until wr_lock[0] falls. After release, req1 is acked within 2 cycles.
